// File: rtl/sint_eq_arbiter.sv
// sint_eq_arbiter: shares one signed equality comparator among N requesters.
// A round-robin arbiter feeds a two-stage pipeline (operands, then result);
// results come back on one tagged response channel with backpressure.

// Bitwise equality primitive, matching the coreir_eq cell used by magma clients.
module coreir_eq #(
  parameter int width = 1
) (
  input  logic [width-1:0] in0,
  input  logic [width-1:0] in1,
  output logic             out
);

  assign out = (in0 == in1);

endmodule

module sint_eq_arbiter #(
  parameter int WIDTH = 3,
  parameter int N     = 4,
  parameter int IDW   = $clog2(N)
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [N-1:0]         REQ_VALID,
  input  logic [N*WIDTH-1:0]   REQ_A,
  input  logic [N*WIDTH-1:0]   REQ_B,
  output logic [N-1:0]         REQ_READY,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [IDW-1:0]       RSP_ID,
  output logic                 RSP_EQ
);

  // Unpacked views of the per-requester operand buses
  logic [WIDTH-1:0] reqA [N];
  logic [WIDTH-1:0] reqB [N];

  for (genvar g = 0; g < N; g++) begin : gUnpack
    assign reqA[g] = REQ_A[g*WIDTH +: WIDTH];
    assign reqB[g] = REQ_B[g*WIDTH +: WIDTH];
  end

  // Stage 1: granted request waiting for the comparator
  logic             s1Valid_q, s1Valid_d;
  logic [IDW-1:0]   s1Id_q,    s1Id_d;
  logic [WIDTH-1:0] s1A_q,     s1A_d;
  logic [WIDTH-1:0] s1B_q,     s1B_d;

  // Stage 2: comparison result presented on the response channel
  logic             s2Valid_q, s2Valid_d;
  logic [IDW-1:0]   s2Id_q,    s2Id_d;
  logic             s2Eq_q,    s2Eq_d;

  // Round-robin search start
  logic [IDW-1:0]   ptr_q,     ptr_d;

  logic             s2Load;
  logic             s1Adv;
  logic             grantFound;
  logic [IDW-1:0]   grantId;
  logic             eqResult;
  logic [N-1:0]     reqReady;

  // The single shared comparator sits between S1 and S2
  coreir_eq #(
    .width (WIDTH)
  ) uEq (
    .in0 (s1A_q),
    .in1 (s1B_q),
    .out (eqResult)
  );

  // Pipeline flow control: a stage may load when its consumer can take its contents
  always_comb begin
    s2Load = !s2Valid_q || RSP_READY;
    s1Adv  = !s1Valid_q || s2Load;
  end

  // Round-robin search: first valid requester at or after ptr, wrapping at N
  always_comb begin
    int             idx;
    logic [IDW-1:0] idxT;
    grantFound = 1'b0;
    grantId    = '0;
    idx        = 0;
    idxT       = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      idxT = IDW'(idx);
      if (!grantFound && REQ_VALID[idxT]) begin
        grantFound = 1'b1;
        grantId    = idxT;
      end
    end
  end

  // Ready is one-hot on the winner, only when S1 can accept and never during reset
  always_comb begin
    reqReady = '0;
    if (ASYNCRESETN && s1Adv && grantFound) begin
      reqReady[grantId] = 1'b1;
    end
  end

  assign REQ_READY = reqReady;

  // Next-state for both stages and the arbitration pointer
  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Id_d    = s1Id_q;
    s1A_d     = s1A_q;
    s1B_d     = s1B_q;
    s2Valid_d = s2Valid_q;
    s2Id_d    = s2Id_q;
    s2Eq_d    = s2Eq_q;
    ptr_d     = ptr_q;
    if (s2Load) begin
      s2Valid_d = s1Valid_q;
      s2Id_d    = s1Id_q;
      s2Eq_d    = eqResult;
    end
    if (s1Adv) begin
      s1Valid_d = grantFound;
      if (grantFound) begin
        s1Id_d = grantId;
        s1A_d  = reqA[grantId];
        s1B_d  = reqB[grantId];
        ptr_d  = (grantId == IDW'(N-1)) ? '0 : grantId + IDW'(1);
      end
    end
  end

  // Stage 1 register; reset drops any in-flight request
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      s1Valid_q <= 1'b0;
      s1Id_q    <= '0;
      s1A_q     <= '0;
      s1B_q     <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Id_q    <= s1Id_d;
      s1A_q     <= s1A_d;
      s1B_q     <= s1B_d;
    end
  end

  // Stage 2 register; drives the response channel directly
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      s2Valid_q <= 1'b0;
      s2Id_q    <= '0;
      s2Eq_q    <= 1'b0;
    end else begin
      s2Valid_q <= s2Valid_d;
      s2Id_q    <= s2Id_d;
      s2Eq_q    <= s2Eq_d;
    end
  end

  // Arbitration pointer, advanced past each winner
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign RSP_VALID = s2Valid_q;
  assign RSP_ID    = s2Id_q;
  assign RSP_EQ    = s2Eq_q;

endmodule

// File: tb/tb_sint_eq_arbiter.sv
// tb_sint_eq_arbiter: scoreboard bench for the shared equality comparator arbiter.
module tb_sint_eq_arbiter;

  localparam int WIDTH = 3;
  localparam int N     = 4;
  localparam int IDW   = 2;

  logic               CLK;
  logic               ASYNCRESETN;
  logic [N-1:0]       REQ_VALID;
  logic [N*WIDTH-1:0] REQ_A;
  logic [N*WIDTH-1:0] REQ_B;
  logic [N-1:0]       REQ_READY;
  logic               RSP_VALID;
  logic               RSP_READY;
  logic [IDW-1:0]     RSP_ID;
  logic               RSP_EQ;

  logic [WIDTH-1:0] aArr [N];
  logic [WIDTH-1:0] bArr [N];

  for (genvar g = 0; g < N; g++) begin : gPack
    assign REQ_A[g*WIDTH +: WIDTH] = aArr[g];
    assign REQ_B[g*WIDTH +: WIDTH] = bArr[g];
  end

  typedef struct {
    logic [IDW-1:0] id;
    logic           eq;
    int             cyc;
  } item_t;

  item_t expQ[$];
  item_t gotQ[$];

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  logic [N-1:0] lastAccept;

  sint_eq_arbiter #(
    .WIDTH (WIDTH),
    .N     (N),
    .IDW   (IDW)
  ) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .REQ_VALID   (REQ_VALID),
    .REQ_A       (REQ_A),
    .REQ_B       (REQ_B),
    .REQ_READY   (REQ_READY),
    .RSP_VALID   (RSP_VALID),
    .RSP_READY   (RSP_READY),
    .RSP_ID      (RSP_ID),
    .RSP_EQ      (RSP_EQ)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One cycle: sample handshakes shortly after the falling edge, record the
  // expected result of every accepted request and every delivered response.
  task automatic step();
    item_t it;
    #1;
    lastAccept = REQ_READY & REQ_VALID;
    for (int i = 0; i < N; i++) begin
      if (lastAccept[i]) begin
        it.id  = IDW'(i);
        it.eq  = (aArr[i] == bArr[i]);
        it.cyc = cycle;
        expQ.push_back(it);
      end
    end
    if (RSP_VALID && RSP_READY) begin
      it.id  = RSP_ID;
      it.eq  = RSP_EQ;
      it.cyc = cycle;
      gotQ.push_back(it);
    end
    @(posedge CLK);
    @(negedge CLK);
    cycle++;
  endtask

  task automatic test_reset();
    ASYNCRESETN = 1'b1;
    REQ_VALID   = '0;
    RSP_READY   = 1'b1;
    for (int i = 0; i < N; i++) begin
      aArr[i] = '0;
      bArr[i] = '0;
    end
    #1;
    ASYNCRESETN = 1'b0;
    REQ_VALID   = 4'b1111;
    @(negedge CLK);
    #1;
    checks++;
    if (REQ_READY !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_req_ready got=%b exp=0000", REQ_READY);
    end
    checks++;
    if (RSP_VALID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_rsp_valid got=%b exp=0", RSP_VALID);
    end
    checks++;
    if (RSP_ID !== 2'd0 || RSP_EQ !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_rsp_data got id=%0d eq=%b exp id=0 eq=0", RSP_ID, RSP_EQ);
    end
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    #1;
    checks++;
    if (REQ_READY !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL first_grant got=%b exp=0001", REQ_READY);
    end
    step();
    RSP_READY = 1'b0;
    repeat (3) step();
    #2;
    checks++;
    if (RSP_VALID !== 1'b1) begin
      failures++;
      $display("[TB] FAIL prefill_rsp_valid got=%b exp=1", RSP_VALID);
    end
    ASYNCRESETN = 1'b0;
    #1;
    checks++;
    if (RSP_VALID !== 1'b0 || REQ_READY !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL async_reset got rsp_valid=%b req_ready=%b exp 0/0000", RSP_VALID, REQ_READY);
    end
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    REQ_VALID   = '0;
    RSP_READY   = 1'b1;
    expQ.delete();
    gotQ.delete();
    repeat (4) step();
    checks++;
    if (gotQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL dropped_inflight got responses=%0d exp=0", gotQ.size());
    end
    REQ_VALID = 4'b1111;
    #1;
    checks++;
    if (REQ_READY !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL grant_after_reset got=%b exp=0001", REQ_READY);
    end
    REQ_VALID = '0;
    repeat (3) step();
    expQ.delete();
    gotQ.delete();
  endtask

  task automatic test_single(input int id, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic expEq);
    item_t e;
    item_t g;
    aArr[id]  = a;
    bArr[id]  = b;
    RSP_READY = 1'b1;
    REQ_VALID = '0;
    REQ_VALID[id] = 1'b1;
    step();
    REQ_VALID = '0;
    repeat (3) step();
    checks++;
    if (expQ.size() != 1 || gotQ.size() != 1) begin
      failures++;
      $display("[TB] FAIL single_count got accepted=%0d responses=%0d exp 1/1", expQ.size(), gotQ.size());
    end else begin
      e = expQ.pop_front();
      g = gotQ.pop_front();
      checks++;
      if (g.id !== IDW'(id) || g.eq !== expEq) begin
        failures++;
        $display("[TB] FAIL single_result got id=%0d eq=%b exp id=%0d eq=%b", g.id, g.eq, id, expEq);
      end
      checks++;
      if (g.eq !== e.eq) begin
        failures++;
        $display("[TB] FAIL single_model got eq=%b exp eq=%b", g.eq, e.eq);
      end
      checks++;
      if (g.cyc - e.cyc != 2) begin
        failures++;
        $display("[TB] FAIL single_latency got=%0d exp=2", g.cyc - e.cyc);
      end
    end
    expQ.delete();
    gotQ.delete();
  endtask

  task automatic test_fairness();
    RSP_READY = 1'b1;
    for (int i = 0; i < N; i++) begin
      aArr[i] = 3'($urandom);
      bArr[i] = (i % 2 == 0) ? aArr[i] : 3'($urandom);
    end
    REQ_VALID = 4'b1111;
    repeat (12) step();
    REQ_VALID = '0;
    repeat (3) step();
    checks++;
    if (expQ.size() != 12 || gotQ.size() != 12) begin
      failures++;
      $display("[TB] FAIL fair_count got accepted=%0d responses=%0d exp 12/12", expQ.size(), gotQ.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (expQ[i].id !== IDW'(i % N) || gotQ[i].id !== IDW'(i % N)) begin
          failures++;
          $display("[TB] FAIL fair_order[%0d] got grant=%0d rsp=%0d exp=%0d", i, expQ[i].id, gotQ[i].id, i % N);
        end
        checks++;
        if (gotQ[i].eq !== expQ[i].eq || gotQ[i].cyc != gotQ[0].cyc + i) begin
          failures++;
          $display("[TB] FAIL fair_rsp[%0d] got eq=%b cyc=%0d exp eq=%b cyc=%0d", i, gotQ[i].eq, gotQ[i].cyc, expQ[i].eq, gotQ[0].cyc + i);
        end
      end
    end
    expQ.delete();
    gotQ.delete();
  endtask

  task automatic test_ptr_skip();
    RSP_READY = 1'b1;
    REQ_VALID = 4'b0001;
    step();
    REQ_VALID = '0;
    repeat (3) step();
    expQ.delete();
    gotQ.delete();
    REQ_VALID = 4'b1001;
    #1;
    checks++;
    if (REQ_READY !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL skip_grant3 got=%b exp=1000", REQ_READY);
    end
    step();
    REQ_VALID = 4'b0001;
    #1;
    checks++;
    if (REQ_READY !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL skip_grant0 got=%b exp=0001", REQ_READY);
    end
    step();
    REQ_VALID = '0;
    repeat (3) step();
    checks++;
    if (gotQ.size() != 2) begin
      failures++;
      $display("[TB] FAIL skip_count got=%0d exp=2", gotQ.size());
    end else if (gotQ[0].id !== 2'd3 || gotQ[1].id !== 2'd0) begin
      failures++;
      $display("[TB] FAIL skip_ids got=%0d,%0d exp=3,0", gotQ[0].id, gotQ[1].id);
    end
    expQ.delete();
    gotQ.delete();
  endtask

  task automatic test_backpressure();
    logic           haveSnap;
    logic [IDW-1:0] snapId;
    logic           snapEq;
    item_t          e;
    item_t          g;
    haveSnap = 1'b0;
    snapId   = '0;
    snapEq   = 1'b0;
    for (int i = 0; i < N; i++) begin
      aArr[i] = IDW'(i) == 2'd1 ? 3'b110 : 3'b010;
      bArr[i] = 3'b010;
    end
    RSP_READY = 1'b0;
    REQ_VALID = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      #1;
      if (RSP_VALID === 1'b1) begin
        if (haveSnap) begin
          checks++;
          if (RSP_ID !== snapId || RSP_EQ !== snapEq) begin
            failures++;
            $display("[TB] FAIL bp_stable got id=%0d eq=%b exp id=%0d eq=%b", RSP_ID, RSP_EQ, snapId, snapEq);
          end
        end else begin
          haveSnap = 1'b1;
          snapId   = RSP_ID;
          snapEq   = RSP_EQ;
        end
      end
    end
    checks++;
    if (expQ.size() != 2 || REQ_READY !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL bp_accepts got=%0d ready=%b exp 2/0000", expQ.size(), REQ_READY);
    end
    RSP_READY = 1'b1;
    REQ_VALID = '0;
    repeat (4) step();
    checks++;
    if (gotQ.size() != 2 || expQ.size() != 2) begin
      failures++;
      $display("[TB] FAIL bp_drain got responses=%0d accepted=%0d exp 2/2", gotQ.size(), expQ.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        e = expQ.pop_front();
        g = gotQ.pop_front();
        checks++;
        if (g.id !== IDW'(i + 1) || g.id !== e.id || g.eq !== e.eq) begin
          failures++;
          $display("[TB] FAIL bp_order[%0d] got id=%0d eq=%b exp id=%0d eq=%b", i, g.id, g.eq, i + 1, e.eq);
        end
      end
    end
    expQ.delete();
    gotQ.delete();
  endtask

  task automatic test_random();
    item_t e;
    item_t g;
    REQ_VALID = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!REQ_VALID[i] && $urandom_range(0, 2) == 0) begin
          aArr[i] = 3'($urandom);
          bArr[i] = ($urandom_range(0, 1) == 1) ? aArr[i] : 3'($urandom);
          REQ_VALID[i] = 1'b1;
        end
      end
      RSP_READY = ($urandom_range(0, 3) != 0);
      step();
      REQ_VALID = REQ_VALID & ~lastAccept;
      while (gotQ.size() > 0) begin
        g = gotQ.pop_front();
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL rand_extra got id=%0d eq=%b exp no response", g.id, g.eq);
        end else begin
          e = expQ.pop_front();
          if (g.id !== e.id || g.eq !== e.eq) begin
            failures++;
            $display("[TB] FAIL rand_rsp got id=%0d eq=%b exp id=%0d eq=%b", g.id, g.eq, e.id, e.eq);
          end
        end
      end
    end
    REQ_VALID = '0;
    RSP_READY = 1'b1;
    repeat (4) step();
    while (gotQ.size() > 0) begin
      g = gotQ.pop_front();
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL rand_tail_extra got id=%0d exp no response", g.id);
      end else begin
        e = expQ.pop_front();
        if (g.id !== e.id || g.eq !== e.eq) begin
          failures++;
          $display("[TB] FAIL rand_tail got id=%0d eq=%b exp id=%0d eq=%b", g.id, g.eq, e.id, e.eq);
        end
      end
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL rand_lost got pending=%0d exp=0", expQ.size());
    end
  endtask

  initial begin
    $display("[TB] starting sint_eq_arbiter bench");
    test_reset();
    test_single(2, 3'b101, 3'b101, 1'b1);
    test_single(2, 3'b011, 3'b100, 1'b0);
    test_single(1, 3'b111, 3'b111, 1'b1);
    test_single(3, 3'b100, 3'b011, 1'b0);
    test_fairness();
    test_ptr_skip();
    test_backpressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
